// File: rtl/ma_pkg.sv
// ma_pkg: shared constants and types for the memory-access stage.
//   OP_LD / OP_ST      : memory opcodes (instruction bits [OPC_HI:OPC_LO])
//   NOP_INST           : all-zero pipeline bubble
//   ma_state_t         : IDLE / BUSY / DONE transfer state
//   opcode_of()        : extracts the opcode field from an instruction word
package ma_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;

    localparam logic [5:0]  OP_LD    = 6'b100011;
    localparam logic [5:0]  OP_ST    = 6'b101011;
    localparam logic [31:0] NOP_INST = 32'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ma_state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] inst);
        return inst[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/ma_stage_if.sv
// ma_stage_if: data-memory req/ack bus between the MA stage and memory.
//   mem_req   : transfer request (master -> slave)
//   mem_we    : 1 = store, 0 = load
//   mem_addr  : word-aligned address
//   mem_wdata : store data
//   mem_rdata : load data, valid with mem_ack (slave -> master)
//   mem_ack   : transfer complete (slave -> master)
interface ma_stage_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/ma_watchdog.sv
// ma_watchdog: BUSY-cycle counter that flags a stuck memory transfer.
//   clk, rst : clock, asynchronous active-high reset
//   start    : clears the counter (transfer being issued)
//   tick     : one BUSY cycle elapsed without ack
//   expired  : this tick brings the count to TIMEOUT_CYCLES
module ma_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic tick,
    output logic expired
);

    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : CW_RAW;

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (start) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Fires on the tick that would make the count equal TIMEOUT_CYCLES, so
    // the stage leaves BUSY after exactly TIMEOUT_CYCLES ack-less cycles.
    assign expired = tick && (count_reg == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ma_stage.sv
// ma_stage: RISC pipeline memory-access stage.
// Decodes the EX/MA instruction, runs LD/ST transfers over the req/ack bus
// and stalls upstream while a transfer is outstanding.
//   clk, rst         : clock, asynchronous active-high reset
//   alu_res_in       : ALU result / memory address
//   op2_in           : store data
//   inst_in          : instruction from EX/MA
//   stall_out        : hold EX/MA while high
//   data_out/inst_out: toward MA/RW register
//   align_err        : sticky misaligned LD/ST flag
//   bus_err          : sticky transfer-timeout flag
//   mem              : data-memory bus (master side)
// Optional feature macro: MA_TIMEOUT_EN enables the transfer watchdog
// (ma_watchdog, TIMEOUT_CYCLES); without it BUSY waits forever and bus_err=0.
module ma_stage
    import ma_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] op2_in,
    input  logic [31:0] inst_in,
    output logic        stall_out,
    output logic [31:0] data_out,
    output logic [31:0] inst_out,
    output logic        align_err,
    output logic        bus_err,
    ma_stage_if.master  mem
);

    ma_state_t   state_reg, state_next;
    logic [31:0] inst_lat_reg;
    logic [31:0] rdata_lat_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        req_reg;
    logic        we_reg;
    logic        align_err_reg;

    logic        is_mem;
    logic        aligned;
    logic        lat_is_ld;
    logic        start_xfer;
    logic        timeout_hit;
    logic        abort_done;

    assign is_mem     = (opcode_of(inst_in) == OP_LD) || (opcode_of(inst_in) == OP_ST);
    assign aligned    = (alu_res_in[1:0] == 2'b00);
    assign lat_is_ld  = (opcode_of(inst_lat_reg) == OP_LD);
    assign start_xfer = (state_reg == IDLE) && is_mem && aligned;

    assign mem.mem_req   = req_reg;
    assign mem.mem_we    = we_reg;
    assign mem.mem_addr  = addr_reg;
    assign mem.mem_wdata = wdata_reg;
    assign align_err     = align_err_reg;

    // Next state and the combinational outputs toward MA/RW.
    always_comb begin
        state_next = state_reg;
        stall_out  = 1'b0;
        data_out   = alu_res_in;
        inst_out   = inst_in;
        case (state_reg)
            IDLE: begin
                if (is_mem) begin
                    inst_out = NOP_INST;
                    data_out = 32'd0;
                    if (aligned) begin
                        stall_out  = 1'b1;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_out = 1'b1;
                inst_out  = NOP_INST;
                data_out  = 32'd0;
                if (mem.mem_ack || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                if (abort_done) begin
                    inst_out = NOP_INST;
                    data_out = 32'd0;
                end else begin
                    inst_out = inst_lat_reg;
                    data_out = lat_is_ld ? rdata_lat_reg : addr_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Transfer latches and bus registers. The latched address doubles as
    // mem_addr and as the ST result presented in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_lat_reg  <= '0;
            rdata_lat_reg <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            req_reg       <= 1'b0;
            we_reg        <= 1'b0;
            align_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (is_mem) begin
                        if (aligned) begin
                            inst_lat_reg <= inst_in;
                            addr_reg     <= {alu_res_in[31:2], 2'b00};
                            wdata_reg    <= op2_in;
                            we_reg       <= (opcode_of(inst_in) == OP_ST);
                            req_reg      <= 1'b1;
                        end else begin
                            align_err_reg <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // Ack wins over a simultaneous timeout.
                    if (mem.mem_ack) begin
                        if (lat_is_ld) begin
                            rdata_lat_reg <= mem.mem_rdata;
                        end
                        req_reg <= 1'b0;
                    end else if (timeout_hit) begin
                        req_reg <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MA_TIMEOUT_EN
    logic bus_err_reg;
    logic abort_reg;

    ma_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .start   (start_xfer),
        .tick    ((state_reg == BUSY) && !mem.mem_ack),
        .expired (timeout_hit)
    );

    // abort_reg marks a DONE reached by timeout so it presents a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err_reg <= 1'b0;
            abort_reg   <= 1'b0;
        end else begin
            if (start_xfer) begin
                abort_reg <= 1'b0;
            end
            if (timeout_hit) begin
                bus_err_reg <= 1'b1;
                abort_reg   <= 1'b1;
            end
        end
    end

    assign bus_err    = bus_err_reg;
    assign abort_done = abort_reg;
`else
    logic unused_timeout_param;

    assign timeout_hit          = 1'b0;
    assign bus_err              = 1'b0;
    assign abort_done           = 1'b0;
    assign unused_timeout_param = (TIMEOUT_CYCLES != 0);
`endif

endmodule
